// File: rtl/aes192_key_expansion.sv
// AES-192 key schedule: expands a 192-bit key into 52 words, one word per clock,
// and presents the whole schedule on a flat 1664-bit bus once finished.

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    // Forward S-box, entry 0 at bit 0 of the ascending range.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[{in_i, 3'b000} +: 8];
endmodule

module aes192_key_expansion (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [191:0]   key,
    output logic [0:1663]  w,
    output logic           busy,
    output logic           done
);
    logic [31:0] words_q [0:51];
    logic [31:0] words_d [0:51];
    logic [5:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] new_word;
    logic [7:0]  rcon;
    logic        rot_step;

    assign prev_word = words_q[idx_q - 6'd1];
    assign back_word = words_q[idx_q - 6'd6];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    // Rcon is only non-zero on the indices that take the RotWord/SubWord path.
    always_comb begin
        rcon = 8'h00;
        case (idx_q)
            6'd6:    rcon = 8'h01;
            6'd12:   rcon = 8'h02;
            6'd18:   rcon = 8'h04;
            6'd24:   rcon = 8'h08;
            6'd30:   rcon = 8'h10;
            6'd36:   rcon = 8'h20;
            6'd42:   rcon = 8'h40;
            6'd48:   rcon = 8'h80;
            default: rcon = 8'h00;
        endcase
    end

    assign rot_step = (rcon != 8'h00);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_i  (rot_word[gi*8 +: 8]),
                .out_o (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    assign new_word = back_word ^ (rot_step ? (sub_word ^ {rcon, 24'h000000}) : prev_word);

    always_comb begin
        words_d = words_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (!busy_q && start) begin
            for (int k = 0; k < 6; k++) begin
                words_d[k] = key[(5-k)*32 +: 32];
            end
            for (int k = 6; k < 52; k++) begin
                words_d[k] = 32'h0;
            end
            idx_d  = 6'd6;
            busy_d = 1'b1;
        end else if (busy_q) begin
            words_d[idx_q] = new_word;
            idx_d          = idx_q + 6'd1;
            if (idx_q == 6'd51) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 52; k++) begin
                words_q[k] <= 32'h0;
            end
            idx_q  <= 6'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            for (int k = 0; k < 52; k++) begin
                words_q[k] <= words_d[k];
            end
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 52; gi++) begin : g_out
            assign w[gi*32 +: 32] = words_q[gi];
        end
    endgenerate

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_aes192_key_expansion.sv
// Bench for aes192_key_expansion: a reference key schedule built from GF(2^8)
// arithmetic, a per-cycle output comparison, and directed FIPS-197 vectors.

module tb_aes192_key_expansion;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [191:0]  key;
    logic [0:1663] w;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [191:0] KEY_C2   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] KEY_A2   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KEY_ZERO = 192'h0;

    aes192_key_expansion dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .w     (w),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference S-box derived from the multiplicative inverse and affine map.
    logic [7:0] sub_m [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sub_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [0:1663] expand(input logic [191:0] k);
        logic [31:0]   ws [0:51];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1663] r;
        for (int i = 0; i < 6; i++) ws[i] = k[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = ws[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sub_m[t[31:24]], sub_m[t[23:16]], sub_m[t[15:8]], sub_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ws[i] = ws[i-6] ^ t;
        end
        for (int i = 0; i < 52; i++) r[i*32 +: 32] = ws[i];
        return r;
    endfunction

    // Model: schedule captured at the accepted start edge; c counts edges since.
    logic          m_active = 1'b0;
    int            m_c      = 0;
    logic [0:1663] m_sched  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_c      <= 0;
        end else if (start && !(m_active && m_c < 46)) begin
            m_active <= 1'b1;
            m_c      <= 0;
            m_sched  <= expand(key);
        end else if (m_active) begin
            m_c <= m_c + 1;
        end
    end

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    logic [0:1663] cmp_exp;
    always @(negedge clk) begin
        int bad;
        for (int i = 0; i < 52; i++)
            cmp_exp[i*32 +: 32] = (m_active && i < 6 + m_c) ? m_sched[i*32 +: 32] : 32'h0;
        check_val("cyc_busy", {127'b0, busy}, {127'b0, (m_active && m_c < 46)});
        check_val("cyc_done", {127'b0, done}, {127'b0, (m_active && m_c == 46)});
        bad = -1;
        for (int i = 51; i >= 0; i--)
            if (w[i*32 +: 32] !== cmp_exp[i*32 +: 32]) bad = i;
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL cyc_w at %0t: word %0d got %h expected %h",
                      $time, bad, w[bad*32 +: 32], cmp_exp[bad*32 +: 32]);
    end

    function automatic logic [31:0] wd(input int i);
        return w[i*32 +: 32];
    endfunction

    function automatic logic [127:0] rk(input int r);
        return w[r*128 +: 128];
    endfunction

    // Launches one expansion; optionally pokes a second start at cycle poke_at.
    task automatic run(input logic [191:0] k, input int poke_at, input logic [191:0] poke_key,
                       output int lat);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == poke_at) begin
                start = 1'b1;
                key   = poke_key;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
                key   = k;
            end
            if (done && lat < 0) lat = n;
            if (lat >= 0) break;
        end
        $display("run key=%h latency=%0d", k, lat);
    endtask

    initial begin
        int lat;
        int dc;
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        repeat (2) @(negedge clk);
        check_val("init_w_nonzero", {127'b0, (w != '0)}, 128'h0);
        check_val("init_busy", {127'b0, busy}, 128'h0);
        check_val("init_done", {127'b0, done}, 128'h0);
        rst = 1'b0;

        run(KEY_ZERO, -1, KEY_ZERO, lat);
        check_val("zero_latency", 128'(lat), 128'd46);
        for (int i = 0; i < 6; i++) check_val("zero_w0_5", {96'b0, wd(i)}, 128'h0);
        check_val("zero_w6", {96'b0, wd(6)}, 128'h62636363);
        check_val("zero_w7", {96'b0, wd(7)}, 128'h62636363);

        run(KEY_C2, 20, KEY_A2, lat);
        check_val("c2_latency", 128'(lat), 128'd46);
        check_val("c2_rk1", rk(1), 128'h10111213141516175846f2f95c43f4fe);
        check_val("c2_rk12", rk(12), 128'ha4970a331a78dc09c418c271e3a41d5d);
        check_val("c2_rk0", rk(0), 128'h000102030405060708090a0b0c0d0e0f);

        run(KEY_A2, -1, KEY_A2, lat);
        check_val("a2_latency", 128'(lat), 128'd46);
        check_val("a2_w6", {96'b0, wd(6)}, 128'hfe0c91f7);
        check_val("a2_w51", {96'b0, wd(51)}, 128'h01002202);

        // Reset asserted mid-cycle while generating.
        @(negedge clk);
        key   = KEY_C2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_w_nonzero", {127'b0, (w != '0)}, 128'h0);
        check_val("arst_busy", {127'b0, busy}, 128'h0);
        check_val("arst_done", {127'b0, done}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        dc  = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dc++;
        end
        check_val("arst_no_done", 128'(dc), 128'd0);

        run(KEY_C2, -1, KEY_C2, lat);
        check_val("restart_latency", 128'(lat), 128'd46);
        check_val("restart_rk12", rk(12), 128'ha4970a331a78dc09c418c271e3a41d5d);

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        key   = KEY_A2;
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        check_val("rst_vs_start_busy", {127'b0, busy}, 128'h0);
        check_val("rst_vs_start_w0", {96'b0, wd(0)}, 128'h0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_vs_start_idle", {127'b0, busy}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes192_key_expansion.md
# aes192_key_expansion

Sequential AES-192 key schedule (FIPS-197). It expands a 192-bit cipher key into the 52 words / 13 round keys consumed by the AES-192 round datapath. Round keys 0–11 feed `round` and `round_inverse`. Round key 12 feeds `last_round` (encrypt), and round key 0 feeds `last_round_inv` (decrypt). The block generates one word per clock and presents the complete schedule on a flat bus once done.

## Interface
- No parameters; Nk=6, Nr=12 and 52 words are fixed.
- `clk` — input, 1 bit. Rising-edge clock.
- `rst` — input, 1 bit. Asynchronous, active-high reset.
- `start` — input, 1 bit. Request expansion of `key`. Sampled only while `busy`=0.
- `key` — input, 192 bits. Cipher key. `key[191:160]` is word 0 and `key[31:0]` is word 5.
- `w` — output, 1664 bits, declared `[0:1663]`. Word i occupies `w[i*32 +: 32]`. Round key r occupies `w[r*128 +: 128]`.
- `busy` — output, 1 bit. High while words 6–51 are being generated.
- `done` — output, 1 bit. One-cycle pulse when word 51 has been written.
- Reset and clocking: one clock; `rst` is asynchronous and active-high.

## Operation
- Word storage is 52 × 32-bit registers. A 6-bit word index `i` is held in a register.
- **Start:** on `start`=1 with `busy`=0:
  - words 0–5 are loaded from `key`;
  - words 6–51 are cleared to zero;
  - `i` is set to 6 and `busy` is set to 1.
- **Generate:** while busy, on each edge, word i is written and `i` increments:
  - if i mod 6 = 0: w[i] = w[i-6] ^ SubWord(RotWord(w[i-1])) ^ {Rcon[i/6], 24'h0};
  - otherwise: w[i] = w[i-6] ^ w[i-1];
  - there is no extra SubWord at i mod 6 = 4; that step applies to AES-256 only.
- **RotWord:** {b0,b1,b2,b3} → {b1,b2,b3,b0}.
- **SubWord:** forward FIPS-197 S-box applied to each of the 4 bytes. It uses 4 S-box instances, combinational, and may use the shared sbox module.
- **Rcon[1..8]:** 01, 02, 04, 08, 10, 20, 40, 80 (hex). The largest index used is 8, at i=48.
- **Finish:** the edge that writes word 51 also clears `busy` and sets `done`. `done` clears on the next edge.
- **Idle:** `w` holds its value indefinitely.
- **Ignored inputs:** `start` while busy is ignored. `key` changes after the start edge are ignored.
- **Valid schedule:** `w` is a valid schedule only when `busy`=0 after a `done` pulse. Consumers must not use it while busy.

## Timing
- **Reset:** asynchronous. `w` = all zeros, `busy`=0, `done`=0, `i`=0. It takes effect immediately regardless of clock.
- **Start edge E0:** words 0–5 are visible right after E0, so round key 0 and words 4–5 are usable then.
- **Generation:** edges E1…E46 write words 6…51, one per edge.
- **Status signals:**
  - `busy` is high from after E0 through E46;
  - `done` is high for exactly the cycle between E46 and E47;
  - total latency is 46 clocks from the start edge to `done`.
- **Back-to-back:** `start` held or asserted in the `done` cycle is accepted at E47, because `busy` is already 0.
- **Reset mid-generation:** all state is cleared. No `done` is produced, and a new `start` is required.
- **Reset vs start:** reset asserted in the same cycle as `start` wins.
- All outputs are registered. There is no combinational path from `start` or `key` to the outputs.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → `w`=0, `busy`=0 and `done`=0 immediately.
- **FIPS-197 C.2 key:** key = 000102030405060708090a0b0c0d0e0f1011121314151617 → after `done`:
  - round key 1 = 10111213141516175846f2f95c43f4fe;
  - round key 12 = a4970a331a78dc09c418c271e3a41d5d.
- **FIPS-197 A.2 key:** key = 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → w[6] = fe0c91f7 and w[51] = 01002202.
- **Zero key:**
  - words 0–5 = 0;
  - w[6] = w[7] = 62636363;
  - `done` exactly 46 cycles after the start edge.
- **Start while busy:** pulse `start` with a different key at cycle 20 → ignored, and the C.2 result is unchanged.
- **Reset at cycle 30, then restart:**
  - no `done` after the reset;
  - after reset release, `start` with the C.2 key gives correct round key 12 and `done` at +46 cycles.
